// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: ID-stage decode results, MEM/WB forwarding taps,
// pipeline control, and the registered EX-stage operand/control outputs.
interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic [1:0]  id_mul_ctrl;
  logic        id_is_mul, id_src1_pc, id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr;
  logic        mem_reg_we, wb_reg_we;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_fwd_data, wb_data;
  logic        flush, hold;
  logic        id_stall;
  logic [31:0] src1, src2, mul_in1, mul_in2;
  logic [3:0]  alu_ctrl;
  logic [1:0]  mul_ctrl;
  logic        ex_valid, ex_is_mul, ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_pc, ex_store_data;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_ctrl, id_mul_ctrl,
           id_is_mul, id_src1_pc, id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr,
           mem_reg_we, wb_reg_we, mem_rd_addr, wb_rd_addr, mem_fwd_data, wb_data,
           flush, hold,
    input  id_stall, src1, src2, mul_in1, mul_in2, alu_ctrl, mul_ctrl,
           ex_valid, ex_is_mul, ex_reg_we, ex_mem_rd, ex_mem_wr,
           ex_rd_addr, ex_pc, ex_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_ctrl, id_mul_ctrl,
           id_is_mul, id_src1_pc, id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr,
           mem_reg_we, wb_reg_we, mem_rd_addr, wb_rd_addr, mem_fwd_data, wb_data,
           flush, hold,
    output id_stall, src1, src2, mul_in1, mul_in2, alu_ctrl, mul_ctrl,
           ex_valid, ex_is_mul, ex_reg_we, ex_mem_rd, ex_mem_wr,
           ex_rd_addr, ex_pc, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall
// detection and bubble insertion on hazards and branch flushes.
module id_ex_stage (
  input  logic   clk,
  input  logic   rst,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_ctrl;
    logic [1:0]  mul_ctrl;
    logic        is_mul, src1_pc, src2_imm, reg_we, mem_rd, mem_wr;
  } stage_t;

  stage_t      r_ex, w_id;
  logic        w_hazard, w_bubble;
  logic [31:0] w_fwd1, w_fwd2;

  always_comb begin
    w_id          = '0;
    w_id.valid    = 1'b1;
    w_id.pc       = bus.id_pc;
    w_id.rs1_data = bus.id_rs1_data;
    w_id.rs2_data = bus.id_rs2_data;
    w_id.imm      = bus.id_imm;
    w_id.rs1_addr = bus.id_rs1_addr;
    w_id.rs2_addr = bus.id_rs2_addr;
    w_id.rd_addr  = bus.id_rd_addr;
    w_id.alu_ctrl = bus.id_alu_ctrl;
    w_id.mul_ctrl = bus.id_mul_ctrl;
    w_id.is_mul   = bus.id_is_mul;
    w_id.src1_pc  = bus.id_src1_pc;
    w_id.src2_imm = bus.id_src2_imm;
    w_id.reg_we   = bus.id_reg_we;
    w_id.mem_rd   = bus.id_mem_rd;
    w_id.mem_wr   = bus.id_mem_wr;
  end

  // A load in EX whose result the decoding instruction needs next cycle.
  assign w_hazard = bus.id_valid & r_ex.valid & r_ex.mem_rd & (r_ex.rd_addr != 5'd0) &
                    ((r_ex.rd_addr == bus.id_rs1_addr) | (r_ex.rd_addr == bus.id_rs2_addr));
  assign bus.id_stall = w_hazard & ~bus.flush;
  assign w_bubble     = bus.flush | w_hazard | ~bus.id_valid;

  // Bubbles clear the whole register so EX sees a clean all-zero NOP.
  always_ff @(posedge clk) begin
    if (!rst)          r_ex <= '0;
    else if (!bus.hold) begin
      if (w_bubble)    r_ex <= '0;
      else             r_ex <= w_id;
    end
  end

  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] reg_data,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [31:0] m_data,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [31:0] w_data
  );
    if (addr == 5'd0)                 return 32'd0;
    else if (m_we && (m_rd == addr))  return m_data;
    else if (w_we && (w_rd == addr))  return w_data;
    else                              return reg_data;
  endfunction

  assign w_fwd1 = fwd_sel(r_ex.rs1_addr, r_ex.rs1_data, bus.mem_reg_we, bus.mem_rd_addr,
                          bus.mem_fwd_data, bus.wb_reg_we, bus.wb_rd_addr, bus.wb_data);
  assign w_fwd2 = fwd_sel(r_ex.rs2_addr, r_ex.rs2_data, bus.mem_reg_we, bus.mem_rd_addr,
                          bus.mem_fwd_data, bus.wb_reg_we, bus.wb_rd_addr, bus.wb_data);

  assign bus.src1          = r_ex.src1_pc  ? r_ex.pc  : w_fwd1;
  assign bus.src2          = r_ex.src2_imm ? r_ex.imm : w_fwd2;
  assign bus.mul_in1       = w_fwd1;
  assign bus.mul_in2       = w_fwd2;
  assign bus.ex_store_data = w_fwd2;
  assign bus.alu_ctrl      = r_ex.alu_ctrl;
  assign bus.mul_ctrl      = r_ex.mul_ctrl;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_is_mul     = r_ex.is_mul;
  assign bus.ex_reg_we     = r_ex.reg_we;
  assign bus.ex_mem_rd     = r_ex.mem_rd;
  assign bus.ex_mem_wr     = r_ex.mem_wr;
  assign bus.ex_rd_addr    = r_ex.rd_addr;
  assign bus.ex_pc         = r_ex.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run against an instruction-level model of what EX should hold.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: the instruction EX currently holds (all-zero when it is a NOP).
  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  alu;
    logic [1:0]  mul;
    logic        is_mul, s1pc, s2imm, we, mrd, mwr;
  } instr_t;
  instr_t m_ex;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    bus.id_alu_ctrl = 0; bus.id_mul_ctrl = 0; bus.id_is_mul = 0; bus.id_src1_pc = 0;
    bus.id_src2_imm = 0; bus.id_reg_we = 0; bus.id_mem_rd = 0; bus.id_mem_wr = 0;
    bus.mem_reg_we = 0; bus.wb_reg_we = 0; bus.mem_rd_addr = 0; bus.wb_rd_addr = 0;
    bus.mem_fwd_data = 0; bus.wb_data = 0; bus.flush = 0; bus.hold = 0;
  endtask

  task automatic random_inputs;
    bus.id_valid = 1'($urandom); bus.id_pc = $urandom; bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
    bus.id_rs1_addr = 5'($urandom_range(0, 3)); bus.id_rs2_addr = 5'($urandom_range(0, 3));
    bus.id_rd_addr = 5'($urandom_range(0, 3)); bus.id_alu_ctrl = 4'($urandom_range(0, 9));
    bus.id_mul_ctrl = 2'($urandom); bus.id_is_mul = 1'($urandom); bus.id_src1_pc = 1'($urandom);
    bus.id_src2_imm = 1'($urandom); bus.id_reg_we = 1'($urandom);
    bus.id_mem_rd = ($urandom_range(0, 2) == 0); bus.id_mem_wr = 1'($urandom);
    bus.mem_reg_we = 1'($urandom); bus.wb_reg_we = 1'($urandom);
    bus.mem_rd_addr = 5'($urandom_range(0, 3)); bus.wb_rd_addr = 5'($urandom_range(0, 3));
    bus.mem_fwd_data = $urandom; bus.wb_data = $urandom;
    bus.flush = ($urandom_range(0, 6) == 0); bus.hold = ($urandom_range(0, 4) == 0);
  endtask

  // Value the instruction in EX should see for a source register right now.
  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic [31:0] stale);
    if (r == 0) return 0;
    if (bus.mem_reg_we && bus.mem_rd_addr == r) return bus.mem_fwd_data;
    if (bus.wb_reg_we && bus.wb_rd_addr == r) return bus.wb_data;
    return stale;
  endfunction

  function automatic logic ref_load_use();
    return bus.id_valid && m_ex.valid && m_ex.mrd && m_ex.rd != 0 &&
           (m_ex.rd == bus.id_rs1_addr || m_ex.rd == bus.id_rs2_addr);
  endfunction

  task automatic test_reset;
    rst = 0;
    random_inputs();
    tick(); tick();
    bus.mem_reg_we = 0; bus.wb_reg_we = 0;
    #1;
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid); end
    n_cmp++; if ({bus.ex_is_mul, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr} !== 4'b0)
      begin n_err++; $display("FAIL reset_flags: got %b want 0000", {bus.ex_is_mul, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr}); end
    n_cmp++; if ({bus.src1, bus.src2} !== 64'd0) begin n_err++; $display("FAIL reset_src: got %h %h want 0 0", bus.src1, bus.src2); end
    n_cmp++; if ({bus.alu_ctrl, bus.mul_ctrl} !== 6'd0) begin n_err++; $display("FAIL reset_ctrl: got %h %h want 0 0", bus.alu_ctrl, bus.mul_ctrl); end
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.id_stall); end
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_addi;
    idle_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rs1_addr = 1; bus.id_rs1_data = 32'h10;
    bus.id_imm = 12; bus.id_rd_addr = 5; bus.id_alu_ctrl = 4'b0000; bus.id_src2_imm = 1; bus.id_reg_we = 1;
    tick();
    bus.id_valid = 0;
    n_cmp++; if (bus.src1 !== 32'h10) begin n_err++; $display("FAIL addi_src1: got %h want 10", bus.src1); end
    n_cmp++; if (bus.src2 !== 32'hC) begin n_err++; $display("FAIL addi_src2: got %h want c", bus.src2); end
    n_cmp++; if ({bus.ex_valid, bus.alu_ctrl, bus.ex_rd_addr, bus.ex_reg_we} !== {1'b1, 4'b0000, 5'd5, 1'b1})
      begin n_err++; $display("FAIL addi_ctrl: got v%b alu%h rd%0d we%b want v1 alu0 rd5 we1", bus.ex_valid, bus.alu_ctrl, bus.ex_rd_addr, bus.ex_reg_we); end
  endtask

  task automatic test_forward;
    idle_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 3; bus.id_rs1_data = 32'h1; bus.id_rd_addr = 9; bus.id_reg_we = 1;
    tick();
    bus.id_valid = 0;
    bus.mem_reg_we = 1; bus.mem_rd_addr = 3; bus.mem_fwd_data = 32'hAAAA;
    bus.wb_reg_we = 1; bus.wb_rd_addr = 3; bus.wb_data = 32'hBBBB;
    #1;
    n_cmp++; if (bus.src1 !== 32'hAAAA) begin n_err++; $display("FAIL fwd_mem_first: got %h want aaaa", bus.src1); end
    bus.mem_reg_we = 0;
    #1;
    n_cmp++; if (bus.src1 !== 32'hBBBB) begin n_err++; $display("FAIL fwd_wb: got %h want bbbb", bus.src1); end
    bus.wb_reg_we = 0;
    #1;
    n_cmp++; if (bus.src1 !== 32'h1) begin n_err++; $display("FAIL fwd_none: got %h want 1", bus.src1); end
    idle_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 0; bus.id_rd_addr = 9; bus.id_reg_we = 1;
    tick();
    bus.id_valid = 0;
    bus.mem_reg_we = 1; bus.mem_rd_addr = 0; bus.mem_fwd_data = 32'hAAAA;
    bus.wb_reg_we = 1; bus.wb_rd_addr = 0; bus.wb_data = 32'hBBBB;
    #1;
    n_cmp++; if (bus.src1 !== 32'h0) begin n_err++; $display("FAIL fwd_x0: got %h want 0", bus.src1); end
    idle_inputs();
  endtask

  task automatic load_lw_x7;
    idle_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 2; bus.id_rd_addr = 7; bus.id_reg_we = 1; bus.id_mem_rd = 1;
    bus.id_src2_imm = 1; bus.id_imm = 32'h40;
    tick();
  endtask

  task automatic present_mul_x8;
    idle_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h204; bus.id_rs1_addr = 7; bus.id_rs2_addr = 2;
    bus.id_rs2_data = 32'h3; bus.id_rd_addr = 8; bus.id_is_mul = 1; bus.id_mul_ctrl = 2'b00; bus.id_reg_we = 1;
  endtask

  task automatic test_load_use;
    load_lw_x7();
    present_mul_x8();
    #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", bus.id_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", bus.ex_valid); end
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_one_cycle: got %b want 0", bus.id_stall); end
    bus.wb_reg_we = 1; bus.wb_rd_addr = 7; bus.wb_data = 32'h1234;
    tick();
    bus.id_valid = 0;
    n_cmp++; if ({bus.ex_valid, bus.ex_is_mul, bus.mul_ctrl} !== 4'b1100)
      begin n_err++; $display("FAIL lu_mul_ctrl: got v%b m%b c%b want v1 m1 c00", bus.ex_valid, bus.ex_is_mul, bus.mul_ctrl); end
    n_cmp++; if (bus.mul_in1 !== 32'h1234) begin n_err++; $display("FAIL lu_mul_in1: got %h want 1234", bus.mul_in1); end
    n_cmp++; if (bus.mul_in2 !== 32'h3) begin n_err++; $display("FAIL lu_mul_in2: got %h want 3", bus.mul_in2); end
    // reset while a stall is pending
    load_lw_x7();
    present_mul_x8();
    rst = 0;
    tick();
    rst = 1;
    n_cmp++; if ({bus.ex_valid, bus.id_stall} !== 2'b00)
      begin n_err++; $display("FAIL rst_mid_stall: got v%b s%b want v0 s0", bus.ex_valid, bus.id_stall); end
    idle_inputs();
  endtask

  task automatic test_flush;
    idle_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 1; bus.id_rs2_addr = 2; bus.id_rd_addr = 3; bus.id_reg_we = 1; bus.flush = 1;
    tick();
    bus.flush = 0; bus.id_valid = 0;
    n_cmp++; if ({bus.ex_valid, bus.ex_reg_we} !== 2'b00)
      begin n_err++; $display("FAIL flush_bubble: got v%b we%b want v0 we0", bus.ex_valid, bus.ex_reg_we); end
    load_lw_x7();
    present_mul_x8();
    bus.flush = 1;
    #1;
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL flush_lu_stall: got %b want 0", bus.id_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_lu_bubble: got %b want 0", bus.ex_valid); end
    idle_inputs();
  endtask

  task automatic test_hold;
    logic [31:0] v;
    idle_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h200; bus.id_rs1_addr = 4; bus.id_rs1_data = 32'h44;
    bus.id_rs2_addr = 5; bus.id_rs2_data = 32'h55; bus.id_rd_addr = 6; bus.id_reg_we = 1;
    tick();
    bus.id_pc = 32'h300; bus.id_rd_addr = 10; bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus.mem_reg_we = 1; bus.mem_rd_addr = 4; bus.mem_fwd_data = v;
      bus.flush = (i == 1);
      tick();
      n_cmp++; if ({bus.ex_valid, bus.ex_pc, bus.ex_rd_addr} !== {1'b1, 32'h200, 5'd6})
        begin n_err++; $display("FAIL hold_frozen[%0d]: got v%b pc%h rd%0d want v1 pc200 rd6", i, bus.ex_valid, bus.ex_pc, bus.ex_rd_addr); end
      n_cmp++; if ({bus.src1, bus.src2} !== {v, 32'h55})
        begin n_err++; $display("FAIL hold_fwd[%0d]: got %h %h want %h 55", i, bus.src1, bus.src2, v); end
    end
    bus.hold = 0; bus.flush = 0; bus.mem_reg_we = 0;
    tick();
    n_cmp++; if ({bus.ex_valid, bus.ex_pc, bus.ex_rd_addr} !== {1'b1, 32'h300, 5'd10})
      begin n_err++; $display("FAIL hold_release: got v%b pc%h rd%0d want v1 pc300 rd10", bus.ex_valid, bus.ex_pc, bus.ex_rd_addr); end
    idle_inputs();
  endtask

  task automatic test_random;
    logic [31:0] e1, e2;
    idle_inputs();
    rst = 0; tick(); rst = 1;
    m_ex = '{default: '0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      random_inputs();
      #1;
      e1 = ref_read(m_ex.a1, m_ex.d1);
      e2 = ref_read(m_ex.a2, m_ex.d2);
      n_cmp++; if (bus.src1 !== (m_ex.s1pc ? m_ex.pc : e1))
        begin n_err++; $display("FAIL rnd_src1 @%0d: got %h want %h", cyc, bus.src1, m_ex.s1pc ? m_ex.pc : e1); end
      n_cmp++; if (bus.src2 !== (m_ex.s2imm ? m_ex.imm : e2))
        begin n_err++; $display("FAIL rnd_src2 @%0d: got %h want %h", cyc, bus.src2, m_ex.s2imm ? m_ex.imm : e2); end
      n_cmp++; if ({bus.mul_in1, bus.mul_in2, bus.ex_store_data} !== {e1, e2, e2})
        begin n_err++; $display("FAIL rnd_mul_st @%0d: got %h %h %h want %h %h %h", cyc, bus.mul_in1, bus.mul_in2, bus.ex_store_data, e1, e2, e2); end
      n_cmp++; if ({bus.ex_valid, bus.ex_is_mul, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_rd_addr,
                    bus.alu_ctrl, bus.mul_ctrl, bus.ex_pc} !==
                   {m_ex.valid, m_ex.is_mul, m_ex.we, m_ex.mrd, m_ex.mwr, m_ex.rd, m_ex.alu, m_ex.mul, m_ex.pc})
        begin n_err++; $display("FAIL rnd_ctrl @%0d: got v%b rd%0d pc%h want v%b rd%0d pc%h", cyc,
                                bus.ex_valid, bus.ex_rd_addr, bus.ex_pc, m_ex.valid, m_ex.rd, m_ex.pc); end
      n_cmp++; if (bus.id_stall !== (ref_load_use() && !bus.flush))
        begin n_err++; $display("FAIL rnd_stall @%0d: got %b want %b", cyc, bus.id_stall, ref_load_use() && !bus.flush); end
      // what EX holds after this edge
      if (bus.hold) ;
      else if (bus.flush || ref_load_use() || !bus.id_valid) m_ex = '{default: '0};
      else m_ex = '{valid: 1'b1, pc: bus.id_pc, d1: bus.id_rs1_data, d2: bus.id_rs2_data, imm: bus.id_imm,
                    a1: bus.id_rs1_addr, a2: bus.id_rs2_addr, rd: bus.id_rd_addr, alu: bus.id_alu_ctrl,
                    mul: bus.id_mul_ctrl, is_mul: bus.id_is_mul, s1pc: bus.id_src1_pc, s2imm: bus.id_src2_imm,
                    we: bus.id_reg_we, mrd: bus.id_mem_rd, mwr: bus.id_mem_wr};
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_flush();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RV32IM core: registers decoded operands and control, resolves operand forwarding from MEM and WB, and drives the EX-stage ALU/multiplier operand and control inputs (src1, src2, alu_ctrl, mul_in1, mul_in2, mul_ctrl). It detects load-use hazards, stalls decode, and inserts bubbles on hazards and branch flushes, so EX only ever sees valid instructions or NOPs.

## Interface

- No parameters; XLEN fixed at 32, register index width fixed at 5.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  decoded PC, register-file reads, sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  source/destination indices.
- id_alu_ctrl  in  4  ALU opcode (0000 ADD … 1001 LUI).
- id_mul_ctrl  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- id_is_mul, id_src1_pc, id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr  in  1 each  decoded control flags.
- mem_reg_we, wb_reg_we  in  1 each  write enables of instructions in MEM and WB.
- mem_rd_addr, wb_rd_addr  in  5 each  their destinations.
- mem_fwd_data, wb_data  in  32 each  their result values.
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX.
- hold  in  1  downstream (memory) stall; freeze this stage.
- id_stall  out  1  load-use stall request to IF/ID.
- src1, src2, mul_in1, mul_in2  out  32 each  operands to ALU/multiplier.
- alu_ctrl  out  4;  mul_ctrl  out  2  registered opcodes.
- ex_valid, ex_is_mul, ex_reg_we, ex_mem_rd, ex_mem_wr  out  1 each.
- ex_rd_addr  out  5;  ex_pc, ex_store_data  out  32 each.

## Operation

- Stage register R holds pc, rs1/rs2 data and addresses, rd, imm, all control fields, and valid.
- Register update priority per edge: rst low > hold > flush > load-use > normal load.
  - rst low: R cleared; every control flag and ex_valid = 0, all data fields = 0 (alu_ctrl = 0000, mul_ctrl = 00).
  - hold: R unchanged; id_stall still computed.
  - flush or load-use: bubble: ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_mul cleared; data fields don't care (cleared).
  - normal: R <= ID inputs; when id_valid = 0, load a bubble.
- Load-use: id_stall = id_valid & ex_valid & ex_mem_rd & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr). Purely combinational; asserted exactly one cycle per hazard unless hold extends it. flush overrides: id_stall = 0 when flush = 1.
- Forwarding (combinational, per source r in {rs1, rs2} of R): if mem_reg_we & mem_rd_addr == r & r != 0 -> mem_fwd_data; else if wb_reg_we & wb_rd_addr == r & r != 0 -> wb_data; else registered data. MEM beats WB. x0 always reads 0.
- fwd1 / fwd2 denote forwarded rs1 / rs2.
- src1 = ex_src1_pc ? ex_pc : fwd1; src2 = ex_src2_imm ? imm : fwd2.
- mul_in1 = fwd1, mul_in2 = fwd2 (never immediate/PC); ex_store_data = fwd2.
- All outputs other than id_stall derive from R plus the forwarding muxes; no reset-state glitches.

## Timing

- Latency: ID inputs appear on outputs 1 cycle after the sampling edge.
- Forwarding is same-cycle combinational from mem_*/wb_* inputs; no added latency.
- Load-use: consumer stalled in ID 1 cycle, bubble enters EX, consumer then gets the load value via MEM->… WB forwarding path (wb_data).
- Simultaneous flush and load-use: bubble inserted, id_stall = 0 (IF/ID is being flushed anyway).
- hold with flush: hold wins; the flush request must be held by its source.
- Reset mid-stall: next cycle ex_valid = 0, id_stall = 0.

## Test plan

- Reset: rst = 0 for 2 cycles with random inputs -> ex_valid = 0, all flags 0, src1 = src2 = 0, id_stall = 0.
- ADDI x5,x1,12 with x1 = 0x10 -> next cycle src1 = 0x10, src2 = 0xC, alu_ctrl = 0000, ex_rd_addr = 5, ex_reg_we = 1.
- Forward priority: R.rs1 = 3 (regfile 0x1), MEM writes x3 = 0xAAAA, WB writes x3 = 0xBBBB -> src1 = 0xAAAA; drop MEM -> 0xBBBB; rs1 = 0 with both writing x0 -> src1 = 0.
- Load-use: LW x7 in EX, ID holds MUL x8,x7,x2 -> id_stall = 1 for 1 cycle, bubble (ex_valid = 0), then MUL with mul_in1 = wb_data = 0x1234, mul_ctrl = 00.
- Flush: flush = 1 with valid ADD in ID -> next cycle ex_valid = 0, ex_reg_we = 0; flush coincident with load-use -> id_stall = 0.
- Hold: hold = 1 for 3 cycles -> R frozen, outputs stable except forwarding muxes tracking mem_*/wb_*; release -> next ID instruction loaded.
